// File: rtl/reg_dump_pkg.sv
// Shared types and sizes for the register-file dump reader.
package reg_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

  // Dump sequencer states. CSUM is only reachable when the checksum beat is built in.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    FIN  = 3'd4
  } dump_state_e;

  // One stream beat as held on the output registers.
  typedef struct packed {
    logic [REG_DATA_W-1:0] data;
    logic [REG_ADDR_W-1:0] addr;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/reg_dump_csum.sv
// XOR accumulator over the words of one dump. Clear wins over enable so a
// new dump always starts from zero.
module reg_dump_csum
  import reg_dump_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [REG_DATA_W-1:0] din,
  output logic [REG_DATA_W-1:0] acc
);

  // Running XOR of every word folded in since the last clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc ^ din;
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Debug read-back engine: walks the register file's second read port from
// FIRST_REG to LAST_REG and streams each word out over valid/ready.
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [REG_ADDR_W-1:0] rf_addr,
  input  logic [REG_DATA_W-1:0] rf_data,
  output logic [REG_DATA_W-1:0] dout,
  output logic [REG_ADDR_W-1:0] dout_addr,
  output logic                  dout_last,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_READ = READ;
  localparam logic [2:0] ST_SEND = SEND;
  localparam logic [2:0] ST_FIN  = FIN;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM = CSUM;
`endif

  localparam logic [REG_ADDR_W-1:0] FIRST_A = FIRST_REG[REG_ADDR_W-1:0];
  localparam logic [REG_ADDR_W-1:0] LAST_A  = LAST_REG[REG_ADDR_W-1:0];

  logic [2:0]            state;
  logic [REG_ADDR_W-1:0] ptr;
  beat_t                 beat_q;
  logic                  hs;
  logic                  last_reg;
  logic                  reg_last_flag;
  logic [2:0]            after_last;

  assign hs        = dout_valid && dout_ready;
  assign last_reg  = (ptr == LAST_A);
  assign rf_addr   = ptr;
  assign dout      = beat_q.data;
  assign dout_addr = beat_q.addr;
  assign dout_last = beat_q.last;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [REG_DATA_W-1:0] csum;

  // Register beats never carry last; the checksum beat closes the dump.
  assign reg_last_flag = 1'b0;
  assign after_last    = ST_CSUM;

  reg_dump_csum u_csum (
    .clk (clk),
    .rst (rst),
    .clr ((state == ST_IDLE) && start),
    .en  ((state == ST_SEND) && hs),
    .din (beat_q.data),
    .acc (csum)
  );
`else
  assign reg_last_flag = last_reg;
  assign after_last    = ST_FIN;
`endif

  // Dump sequencer: one READ/SEND pair per register, outputs held until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= FIRST_A;
      beat_q     <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          ptr <= FIRST_A;
          if (start) begin
            state <= ST_READ;
            busy  <= 1'b1;
          end
        end
        ST_READ: begin
          // rf_data is combinational off rf_addr, so it is the word at ptr now.
          beat_q.data <= rf_data;
          beat_q.addr <= ptr;
          beat_q.last <= reg_last_flag;
          dout_valid  <= 1'b1;
          state       <= ST_SEND;
        end
        ST_SEND: begin
          if (hs) begin
            dout_valid <= 1'b0;
            // Test for the end before incrementing so ptr never wraps past 31.
            if (last_reg) state <= after_last;
            else begin
              ptr   <= ptr + 1'b1;
              state <= ST_READ;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          // First cycle loads the checksum beat, then wait for its handshake.
          if (!dout_valid) begin
            beat_q.data <= csum;
            beat_q.addr <= '0;
            beat_q.last <= 1'b1;
            dout_valid  <= 1'b1;
          end else if (dout_ready) begin
            dout_valid <= 1'b0;
            state      <= ST_FIN;
          end
        end
`endif
        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          ptr   <= FIRST_A;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: three instances cover the full file,
// a 4..6 window and a 0..2 window (checksum beat when REG_DUMP_CHECKSUM_EN).
module tb_reg_dump_reader;

  localparam int CS =
`ifdef REG_DUMP_CHECKSUM_EN
    1;
`else
    0;
`endif

  logic        clk;
  logic        rst;
  logic        st  [3];
  logic        rdy [3];
  logic [4:0]  ra  [3];
  logic [31:0] rfd [3];
  logic [31:0] dd  [3];
  logic [4:0]  da  [3];
  logic        dl  [3];
  logic        dv  [3];
  logic        bz  [3];
  logic        dn  [3];
  logic [31:0] rfm [3][32];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] bd [$];
  int          ba [$];
  logic        bl [$];
  int          bc [$];
  int          ndone;
  int          done_cyc;
  logic        busy_at_done;
  bit          timed_out;

  assign rfd[0] = rfm[0][ra[0]];
  assign rfd[1] = rfm[1][ra[1]];
  assign rfd[2] = rfm[2][ra[2]];

  reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .rf_addr(ra[0]), .rf_data(rfd[0]),
    .dout(dd[0]), .dout_addr(da[0]), .dout_last(dl[0]), .dout_valid(dv[0]),
    .dout_ready(rdy[0]), .busy(bz[0]), .done(dn[0]));

  reg_dump_reader #(.FIRST_REG(4), .LAST_REG(6)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .rf_addr(ra[1]), .rf_data(rfd[1]),
    .dout(dd[1]), .dout_addr(da[1]), .dout_last(dl[1]), .dout_valid(dv[1]),
    .dout_ready(rdy[1]), .busy(bz[1]), .done(dn[1]));

  reg_dump_reader #(.FIRST_REG(0), .LAST_REG(2)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .rf_addr(ra[2]), .rf_data(rfd[2]),
    .dout(dd[2]), .dout_addr(da[2]), .dout_last(dl[2]), .dout_valid(dv[2]),
    .dout_ready(rdy[2]), .busy(bz[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  // Drive ready and record handshaken beats at each falling edge. Optional
  // stall on one address, optional extra start pulse, optional early stop.
  task automatic collect(input int d, input int stall_addr, input int stall_n,
                         input int start_at, input int stop_beats);
    int stalled = 0;
    logic [31:0] hd = '0;
    logic [4:0]  ha = '0;
    bd.delete(); ba.delete(); bl.delete(); bc.delete();
    ndone = 0; done_cyc = -1; busy_at_done = 1'bx; timed_out = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      st[d] = (c == start_at);
      if (dn[d]) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c;
          busy_at_done = bz[d];
        end
      end
      if (stalled > 0 && stalled < stall_n) begin
        check("stall_valid", 32'(dv[d]), 32'd1);
        check("stall_dout", dd[d], hd);
        check("stall_addr", 32'(da[d]), 32'(ha));
        stalled++;
        rdy[d] = 1'b0;
      end else if (stalled == 0 && stall_n > 0 && dv[d] && da[d] == stall_addr[4:0]) begin
        hd = dd[d]; ha = da[d];
        stalled = 1;
        rdy[d] = 1'b0;
      end else begin
        rdy[d] = 1'b1;
      end
      if (dv[d] && rdy[d]) begin
        bd.push_back(dd[d]); ba.push_back(int'(da[d])); bl.push_back(dl[d]); bc.push_back(c);
        if (stop_beats > 0 && bd.size() == stop_beats) begin
          timed_out = 1'b0;
          return;
        end
      end
      if (done_cyc >= 0 && c >= done_cyc + 4) begin
        timed_out = 1'b0;
        return;
      end
    end
    st[d] = 1'b0;
  endtask

  // Compare the recorded beats against the bench's register model.
  task automatic verify(input int d, input int first, input int last, input string tag);
    int nreg = last - first + 1;
    int n = nreg + CS;
    logic [31:0] x = '0;
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_beats"}, 32'(bd.size()), 32'(n));
    for (int i = 0; i < n && i < bd.size(); i++) begin
      if (i < nreg) begin
        check({tag, "_data"}, bd[i], rfm[d][first + i]);
        check({tag, "_addr"}, 32'(ba[i]), 32'(first + i));
        check({tag, "_last"}, 32'(bl[i]), 32'((CS == 0) && (i == nreg - 1)));
        x ^= rfm[d][first + i];
      end else begin
        check({tag, "_csum_data"}, bd[i], x);
        check({tag, "_csum_addr"}, 32'(ba[i]), 32'd0);
        check({tag, "_csum_last"}, 32'(bl[i]), 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      rdy[k] = 1'b0;
      for (int r = 0; r < 32; r++) rfm[k][r] = 32'hDEAD_0000 + 32'(r);
    end
    #2;
    // Reset state
    check("rst_dout", dd[0], 32'h0);
    check("rst_addr", 32'(da[0]), 32'd0);
    check("rst_last", 32'(dl[0]), 32'd0);
    check("rst_valid", 32'(dv[0]), 32'd0);
    check("rst_busy", 32'(bz[0]), 32'd0);
    check("rst_done", 32'(dn[0]), 32'd0);
    check("rst_rf_addr0", 32'(ra[0]), 32'd0);
    check("rst_rf_addr1", 32'(ra[1]), 32'd4);
    @(negedge clk);
    rst = 1'b0;

    // Full 32-register dump, ready held high
    for (int r = 0; r < 32; r++) rfm[0][r] = 32'hA000_0000 + 32'(r);
    pulse_start(0);
    check("lat_busy", 32'(bz[0]), 32'd1);
    check("lat_valid_early", 32'(dv[0]), 32'd0);
    collect(0, -1, 0, -1, 0);
    verify(0, 0, 31, "full");
    if (bc.size() == 32 + CS) begin
      check("lat_first_beat", 32'(bc[0]), 32'd0);
      check("full_spacing", 32'(bc[31 + CS] - bc[0]), 32'(2 * (31 + CS)));
      check("done_delay", 32'(done_cyc - bc[31 + CS]), 32'd2);
    end
    check("full_ndone", 32'(ndone), 32'd1);
    check("busy_with_done", 32'(busy_at_done), 32'd0);
    check("full_idle_valid", 32'(dv[0]), 32'd0);

    // Window 4..6
    rfm[1][4] = 32'h11; rfm[1][5] = 32'h22; rfm[1][6] = 32'h33;
    pulse_start(1);
    collect(1, -1, 0, -1, 0);
    verify(1, 4, 6, "win");
    check("win_ndone", 32'(ndone), 32'd1);

    // Backpressure on beat 3 for five cycles
    pulse_start(0);
    collect(0, 3, 5, -1, 0);
    verify(0, 0, 31, "stall");

    // Extra starts mid-dump and coinciding with the final handshake
    pulse_start(0);
    collect(0, -1, 0, 5, 0);
    verify(0, 0, 31, "dup_mid");
    check("dup_mid_ndone", 32'(ndone), 32'd1);
    check("dup_mid_busy", 32'(bz[0]), 32'd0);
    pulse_start(0);
    collect(0, -1, 0, 62 + 2 * CS, 0);
    verify(0, 0, 31, "dup_end");
    check("dup_end_ndone", 32'(ndone), 32'd1);
    check("dup_end_busy", 32'(bz[0]), 32'd0);
    check("dup_end_valid", 32'(dv[0]), 32'd0);

    // Asynchronous reset after beat 10, then a clean restart
    pulse_start(0);
    collect(0, -1, 0, -1, 11);
    check("pre_rst_beats", 32'(bd.size()), 32'd11);
    @(posedge clk);
    #3;
    check("pre_rst_busy", 32'(bz[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_dout", dd[0], 32'h0);
    check("arst_addr", 32'(da[0]), 32'd0);
    check("arst_last", 32'(dl[0]), 32'd0);
    check("arst_valid", 32'(dv[0]), 32'd0);
    check("arst_busy", 32'(bz[0]), 32'd0);
    check("arst_done", 32'(dn[0]), 32'd0);
    check("arst_rf_addr", 32'(ra[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("arst_no_done", 32'(dn[0]), 32'd0);
    end
    pulse_start(0);
    collect(0, -1, 0, -1, 0);
    verify(0, 0, 31, "restart");

    // Window 0..2 with checksum-friendly data
    rfm[2][0] = 32'hF0F0_0000; rfm[2][1] = 32'h0F0F_0000; rfm[2][2] = 32'h0000_FFFF;
    pulse_start(2);
    collect(2, -1, 0, -1, 0);
    verify(2, 0, 2, "small");
`ifdef REG_DUMP_CHECKSUM_EN
    if (bd.size() == 4) check("csum_value", bd[3], 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
